// File: rtl/sorting_pkg.sv
// Shared types and helpers for the counting-sort engine: FSM states,
// direction encoding and lane addressing within a packed element bus.
package sorting_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EMIT,
    DONE
  } state_t;

  localparam logic ASC  = 1'b0;
  localparam logic DESC = 1'b1;

  // LSB position of a lane inside a packed bus of width-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sort_histogram.sv
// Bucket counters for the counting sorter: one CNT_W counter per possible
// element value, with clear, increment and decrement ports and a combinational read.
module sort_histogram
  import sorting_pkg::*;
#(
  parameter int ELEM_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr,
  input  logic              inc,
  input  logic [ELEM_W-1:0] inc_idx,
  input  logic              dec,
  input  logic [ELEM_W-1:0] dec_idx,
  input  logic [ELEM_W-1:0] rd_idx,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam int BUCKETS = 1 << ELEM_W;

  logic [CNT_W-1:0] count [BUCKETS];

  // NOTE: the counters are a handful of flops, not a RAM, so they take the
  // async reset like any other state; a real memory macro could not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < BUCKETS; b++) count[b] <= '0;
    end else if (clr) begin
      for (int b = 0; b < BUCKETS; b++) count[b] <= '0;
    end else begin
      if (inc) count[inc_idx] <= count[inc_idx] + 1'b1;
      if (dec) count[dec_idx] <= count[dec_idx] - 1'b1;
    end
  end

  assign rd_cnt = count[rd_idx];

endmodule

// File: rtl/counting_sorter.sv
// Counting-sort engine: captures NUM_ELEMS packed values on start, builds a
// histogram one lane per cycle, then scans buckets in the selected order.
module counting_sorter
  import sorting_pkg::*;
#(
  parameter int NUM_ELEMS = 8,
  parameter int ELEM_W    = 4,
  parameter int CNT_W     = $clog2(NUM_ELEMS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        desc_i,
  input  logic [NUM_ELEMS*ELEM_W-1:0] nums_i,
  output logic                        busy_o,
  output logic                        valid_o,
  output logic [NUM_ELEMS*ELEM_W-1:0] sorted_nums_o
);

  localparam int                IDX_W      = $clog2(NUM_ELEMS);
  localparam logic [IDX_W-1:0]  LAST       = IDX_W'(NUM_ELEMS - 1);
  localparam logic [ELEM_W-1:0] TOP_BUCKET = '1;

  state_t                      state, state_nxt;
  logic [NUM_ELEMS*ELEM_W-1:0] data_q;
  logic                        desc_q;
  logic [IDX_W-1:0]            lane, slot;
  logic [ELEM_W-1:0]           bucket, bucket_step, lane_val;
  logic [CNT_W-1:0]            cnt;
  logic                        hist_clr, hist_inc, hist_dec;

  assign lane_val    = data_q[lane_lsb(32'(lane), ELEM_W) +: ELEM_W];
  assign bucket_step = (desc_q == DESC) ? bucket - 1'b1 : bucket + 1'b1;

  sort_histogram #(
    .ELEM_W (ELEM_W),
    .CNT_W  (CNT_W)
  ) u_hist (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (hist_clr),
    .inc     (hist_inc),
    .inc_idx (lane_val),
    .dec     (hist_dec),
    .dec_idx (bucket),
    .rd_idx  (bucket),
    .rd_cnt  (cnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    hist_clr  = 1'b0;
    hist_inc  = 1'b0;
    hist_dec  = 1'b0;
    case (state)
      IDLE, DONE: if (start_i) begin
        state_nxt = COUNT;
        hist_clr  = 1'b1;
      end
      COUNT: begin
        hist_inc = 1'b1;
        if (lane == LAST) state_nxt = EMIT;
      end
      EMIT: if (cnt != '0) begin
        hist_dec = 1'b1;
        if (slot == LAST) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q        <= '0;
      desc_q        <= ASC;
      lane          <= '0;
      slot          <= '0;
      bucket        <= '0;
      sorted_nums_o <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start_i) begin
          data_q        <= nums_i;
          desc_q        <= desc_i;
          lane          <= '0;
          slot          <= '0;
          sorted_nums_o <= '0;
        end
        COUNT: begin
          lane <= lane + 1'b1;
          if (lane == LAST) bucket <= (desc_q == DESC) ? TOP_BUCKET : '0;
        end
        EMIT: begin
          if (cnt == '0) begin
            bucket <= bucket_step;
          end else begin
            sorted_nums_o[lane_lsb(32'(slot), ELEM_W) +: ELEM_W] <= bucket;
            // Freeze slot and bucket on the final write so the index never wraps.
            if (slot != LAST) begin
              slot <= slot + 1'b1;
              if (cnt == CNT_W'(1)) bucket <= bucket_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (state == COUNT) || (state == EMIT);
  assign valid_o = (state == DONE);

endmodule

// File: tb/tb_counting_sorter.sv
// Scoreboard bench for counting_sorter: an 8x4 instance with directed cases
// and a 16x3 instance with random vectors, both against a sort-based model.
module tb_counting_sorter;

  localparam int NA = 8;
  localparam int WA = 4;
  localparam int NB = 16;
  localparam int WB = 3;

  typedef struct packed {
    logic [63:0] res;
    int          edge_at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             a_start, a_desc, a_busy, a_valid, a_valid_d;
  logic [NA*WA-1:0] a_nums, a_sorted;
  logic             b_start, b_desc, b_busy, b_valid, b_valid_d;
  logic [NB*WB-1:0] b_nums, b_sorted;

  counting_sorter #(.NUM_ELEMS(NA), .ELEM_W(WA)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .desc_i(a_desc), .nums_i(a_nums),
    .busy_o(a_busy), .valid_o(a_valid), .sorted_nums_o(a_sorted)
  );

  counting_sorter #(.NUM_ELEMS(NB), .ELEM_W(WB)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .desc_i(b_desc), .nums_i(b_nums),
    .busy_o(b_busy), .valid_o(b_valid), .sorted_nums_o(b_sorted)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain queue sort, plus the count of empty buckets visited
  // before the scan reaches the last occupied bucket.
  function automatic exp_t model(input logic [63:0] nums, input bit desc,
                                 input int n, input int w, input int start_edge);
    exp_t r;
    int   vals[$];
    bit   occ[256];
    int   distinct = 0;
    int   mn = 255;
    int   mx = 0;
    int   e;
    for (int i = 0; i < n; i++) begin
      int v = int'((nums >> (i * w)) & ((64'd1 << w) - 1));
      vals.push_back(v);
      if (!occ[v]) distinct++;
      occ[v] = 1'b1;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    if (desc) vals.rsort();
    else      vals.sort();
    r.res = '0;
    for (int i = 0; i < n; i++) r.res |= 64'(vals[i]) << (i * w);
    e = desc ? ((1 << w) - mn - distinct) : (mx + 1 - distinct);
    r.edge_at = start_edge + 2 * n + e;
    return r;
  endfunction

  always @(negedge clk) begin
    if (a_valid && !a_valid_d) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_valid: actual=1 required=0 (t=%0t)", $time);
      end else begin
        check("a_result", 64'(a_sorted), q_a[0].res);
        check("a_latency", cyc, q_a[0].edge_at);
        check("a_busy_in_done", a_busy, 0);
        q_a.delete(0);
      end
    end
    a_valid_d <= a_valid;
  end

  always @(negedge clk) begin
    if (b_valid && !b_valid_d) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_valid: actual=1 required=0 (t=%0t)", $time);
      end else begin
        check("b_result", 64'(b_sorted), q_b[0].res);
        check("b_latency", cyc, q_b[0].edge_at);
        q_b.delete(0);
      end
    end
    b_valid_d <= b_valid;
  end

  task automatic start_sort(input bit sel, input logic [63:0] d, input bit desc, input bit push);
    @(negedge clk);
    if (!sel) begin
      a_nums = d[NA*WA-1:0]; a_desc = desc; a_start = 1'b1;
      if (push) q_a.push_back(model(d, desc, NA, WA, cyc + 1));
    end else begin
      b_nums = d[NB*WB-1:0]; b_desc = desc; b_start = 1'b1;
      if (push) q_b.push_back(model(d, desc, NB, WB, cyc + 1));
    end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
    if (!sel) begin
      check("a_busy_after_start", a_busy, 1);
      check("a_valid_dropped", a_valid, 0);
    end else begin
      check("b_busy_after_start", b_busy, 1);
    end
  endtask

  task automatic wait_done(input bit sel);
    int n = 0;
    while (((!sel && q_a.size() != 0) || (sel && q_b.size() != 0)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL %s_timeout: valid never rose within 200 cycles", sel ? "b" : "a");
      q_a.delete();
      q_b.delete();
    end
  endtask

  initial begin
    a_start = 1'b0; a_desc = 1'b0; a_nums = '0; a_valid_d = 1'b0;
    b_start = 1'b0; b_desc = 1'b0; b_nums = '0; b_valid_d = 1'b0;

    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_busy", a_busy, 0);
    check("reset_valid", a_valid, 0);
    check("reset_sorted", 64'(a_sorted), 0);
    @(negedge clk);
    rst = 1'b0;

    // Lanes 0..7 = 3,1,4,1,5,9,2,6 (lane 0 in the low nibble).
    start_sort(0, 64'h6295_1413, 0, 1); wait_done(0);
    start_sort(0, 64'h6295_1413, 1, 1); wait_done(0);
    start_sort(0, 64'h0000_0000, 0, 1); wait_done(0);
    start_sort(0, 64'hFFFF_FFFF, 0, 1); wait_done(0);
    start_sort(0, 64'hFFFF_FFFF, 1, 1); wait_done(0);

    // Second start pulse on edge 5 of a running sort must be ignored.
    start_sort(0, 64'h1357_9BDF, 0, 1);
    repeat (3) @(negedge clk);
    a_start = 1'b1; a_nums = 32'h0123_4567; a_desc = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("a_busy_ignored_start", a_busy, 1);
    wait_done(0);

    // Restart straight from DONE: lanes 7,7,0,0,1,1,2,2.
    start_sort(0, 64'h2211_0077, 0, 1); wait_done(0);

    // Asynchronous reset partway through EMIT, then a fresh sort.
    start_sort(0, 64'h8A3C_5E71, 0, 0);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_busy", a_busy, 0);
    check("midreset_valid", a_valid, 0);
    check("midreset_sorted", 64'(a_sorted), 0);
    @(negedge clk);
    rst = 1'b0;
    start_sort(0, 64'h8A3C_5E71, 1, 1); wait_done(0);

    for (int i = 0; i < 10; i++) begin
      start_sort(0, 64'($urandom), $urandom_range(1, 0) == 1, 1);
      wait_done(0);
    end

    for (int i = 0; i < 30; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom} & 64'h0000_FFFF_FFFF_FFFF;
      if (i % 5 == 0) d &= 64'h0000_9249_2492_4924;
      start_sort(1, d, (i % 2) == 1, 1);
      wait_done(1);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
